// File: rtl/demux_pkg.sv
// Shared constants and helpers for the stream_demux2 slice.
package demux_pkg;

    localparam int   FIFO_DEPTH = 2;
    localparam logic SEL_OUT0   = 1'b0;
    localparam logic SEL_OUT1   = 1'b1;
    localparam int   STAT_W     = 16;

    typedef logic [1:0] fifo_cnt_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO with registered storage; head_data reads zero while empty.
module demux_fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    fifo_cnt_t        count;
    logic             do_push;
    logic             do_pop;

    assign valid     = (count != 2'd0);
    assign full      = (count == 2'(FIFO_DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && valid;
    assign head_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // push and pop together leave the count unchanged
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stream_demux2.sv
// Registered 1-to-2 stream demux: each accepted word goes to out0 or out1 by in_sel.
// Optional pop counters per output are enabled with DEMUX_STATS_EN.
module stream_demux2
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [WIDTH-1:0]  out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
`ifdef DEMUX_STATS_EN
    output logic [WIDTH-1:0]  out1_data,
    output logic [STAT_W-1:0] stat0_cnt,
    output logic [STAT_W-1:0] stat1_cnt
`else
    output logic [WIDTH-1:0]  out1_data
`endif
);

    logic full0;
    logic full1;
    logic push0;
    logic push1;

    // in_ready looks only at the selected FIFO's fullness, never at the consumers
    assign in_ready = (in_sel == SEL_OUT1) ? !full1 : !full0;
    assign push0    = in_valid && in_ready && (in_sel == SEL_OUT0);
    assign push1    = in_valid && in_ready && (in_sel == SEL_OUT1);

    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (in_data),
        .pop       (out0_ready),
        .full      (full0),
        .valid     (out0_valid),
        .head_data (out0_data)
    );

    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (in_data),
        .pop       (out1_ready),
        .full      (full1),
        .valid     (out1_valid),
        .head_data (out1_data)
    );

`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat0_cnt <= '0;
            stat1_cnt <= '0;
        end else begin
            if (out0_valid && out0_ready) begin
                stat0_cnt <= sat_inc(stat0_cnt);
            end
            if (out1_valid && out1_ready) begin
                stat1_cnt <= sat_inc(stat1_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// Self-checking bench for stream_demux2: directed vector table plus queue-model random run.
module tb_stream_demux2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel;
    logic [31:0] in_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out0_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out1_data;
`ifdef DEMUX_STATS_EN
    logic [15:0] stat0_cnt;
    logic [15:0] stat1_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          st0;
    int          st1;

    always #5 clk = ~clk;

    stream_demux2 #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
`ifdef DEMUX_STATS_EN
        .out1_data  (out1_data),
        .stat0_cnt  (stat0_cnt),
        .stat1_cnt  (stat1_cnt)
`else
        .out1_data  (out1_data)
`endif
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic        sel;
        logic [31:0] d;
        logic        r0;
        logic        r1;
        logic        chk;
        logic        e_ir;
        logic        e_v0;
        logic [31:0] e_d0;
        logic        e_v1;
        logic [31:0] e_d1;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic rst, iv, sel, input logic [31:0] d,
                                input logic r0, r1, chk, e_ir, e_v0,
                                input logic [31:0] e_d0, input logic e_v1,
                                input logic [31:0] e_d1);
        vec_t v;
        v.rst = rst; v.iv = iv; v.sel = sel; v.d = d; v.r0 = r0; v.r1 = r1;
        v.chk = chk; v.e_ir = e_ir; v.e_v0 = e_v0; v.e_d0 = e_d0;
        v.e_v1 = e_v1; v.e_d1 = e_d1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // one clock of stimulus, compared against the queue model, then the model advances
    task automatic cycle(input logic rst, iv, sel, input logic [31:0] d, input logic r0, r1);
        logic        e_ir, e_v0, e_v1, accept;
        logic [31:0] e_d0, e_d1;
        rst_n = rst; in_valid = iv; in_sel = sel; in_data = d;
        out0_ready = r0; out1_ready = r1;
        #1;
        e_v0 = (q0.size() > 0);
        e_v1 = (q1.size() > 0);
        e_d0 = e_v0 ? q0[0] : 32'h0;
        e_d1 = e_v1 ? q1[0] : 32'h0;
        e_ir = ((sel ? q1.size() : q0.size()) < 2);
        check("in_ready", {31'b0, in_ready}, {31'b0, e_ir});
        check("out0_valid", {31'b0, out0_valid}, {31'b0, e_v0});
        check("out0_data", out0_data, e_d0);
        check("out1_valid", {31'b0, out1_valid}, {31'b0, e_v1});
        check("out1_data", out1_data, e_d1);
`ifdef DEMUX_STATS_EN
        check("stat0_cnt", {16'b0, stat0_cnt}, st0);
        check("stat1_cnt", {16'b0, stat1_cnt}, st1);
`endif
        @(posedge clk);
        #1;
        if (!rst) begin
            q0.delete(); q1.delete(); st0 = 0; st1 = 0;
        end else begin
            accept = iv && e_ir;
            if (e_v0 && r0) begin
                void'(q0.pop_front());
                if (st0 < 65535) st0++;
            end
            if (e_v1 && r1) begin
                void'(q1.pop_front());
                if (st1 < 65535) st1++;
            end
            if (accept) begin
                if (sel) q1.push_back(d);
                else     q0.push_back(d);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;

        //               rst iv sel data           r0 r1 chk ir v0 d0            v1 d1
        vecs[0]  = mk(0, 1, 1, 32'h11,         1, 1, 0, 1, 0, 32'h0,          0, 32'h0);
        vecs[1]  = mk(0, 1, 0, 32'h22,         1, 1, 1, 1, 0, 32'h0,          0, 32'h0);
        vecs[2]  = mk(1, 0, 0, 32'h0,          1, 1, 1, 1, 0, 32'h0,          0, 32'h0);
        vecs[3]  = mk(1, 1, 0, 32'hDEADBEEF,   1, 1, 1, 1, 0, 32'h0,          0, 32'h0);
        vecs[4]  = mk(1, 0, 0, 32'h0,          0, 1, 1, 1, 1, 32'hDEADBEEF,   0, 32'h0);
        vecs[5]  = mk(1, 0, 0, 32'h0,          1, 1, 1, 1, 1, 32'hDEADBEEF,   0, 32'h0);
        vecs[6]  = mk(1, 1, 1, 32'hA1,         1, 0, 1, 1, 0, 32'h0,          0, 32'h0);
        vecs[7]  = mk(1, 1, 1, 32'hA2,         1, 0, 1, 1, 0, 32'h0,          1, 32'hA1);
        vecs[8]  = mk(1, 1, 1, 32'hA3,         1, 0, 1, 0, 0, 32'h0,          1, 32'hA1);
        vecs[9]  = mk(1, 1, 1, 32'hA3,         1, 1, 1, 0, 0, 32'h0,          1, 32'hA1);
        vecs[10] = mk(1, 1, 1, 32'hA3,         1, 0, 1, 1, 0, 32'h0,          1, 32'hA2);
        vecs[11] = mk(1, 1, 0, 32'h1,          1, 0, 1, 1, 0, 32'h0,          1, 32'hA2);
        vecs[12] = mk(1, 1, 0, 32'h2,          1, 0, 1, 1, 1, 32'h1,          1, 32'hA2);
        vecs[13] = mk(1, 1, 0, 32'h3,          1, 0, 1, 1, 1, 32'h2,          1, 32'hA2);
        vecs[14] = mk(1, 1, 0, 32'h4,          1, 0, 1, 1, 1, 32'h3,          1, 32'hA2);
        vecs[15] = mk(1, 0, 0, 32'h0,          1, 0, 1, 1, 1, 32'h4,          1, 32'hA2);
        vecs[16] = mk(1, 0, 1, 32'h0,          0, 0, 1, 0, 0, 32'h0,          1, 32'hA2);
        vecs[17] = mk(1, 0, 1, 32'h0,          0, 1, 1, 0, 0, 32'h0,          1, 32'hA2);
        vecs[18] = mk(1, 0, 1, 32'h0,          0, 1, 1, 1, 0, 32'h0,          1, 32'hA3);
        vecs[19] = mk(1, 0, 1, 32'h0,          0, 1, 1, 1, 0, 32'h0,          0, 32'h0);

        for (int i = 0; i < 20; i++) begin
            rst_n = vecs[i].rst; in_valid = vecs[i].iv; in_sel = vecs[i].sel;
            in_data = vecs[i].d; out0_ready = vecs[i].r0; out1_ready = vecs[i].r1;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ir});
                check($sformatf("vec%0d out0_valid", i), {31'b0, out0_valid}, {31'b0, vecs[i].e_v0});
                check($sformatf("vec%0d out0_data", i), out0_data, vecs[i].e_d0);
                check($sformatf("vec%0d out1_valid", i), {31'b0, out1_valid}, {31'b0, vecs[i].e_v1});
                check($sformatf("vec%0d out1_data", i), out1_data, vecs[i].e_d1);
            end
            @(posedge clk);
            #1;
        end

        // plain reset so the stats model starts from a known zero
        rst_n = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        q0.delete(); q1.delete(); st0 = 0; st1 = 0;

        // fill both FIFOs, drain a little for nonzero stats, then reset mid-stream
        cycle(1, 1, 0, 32'h100, 0, 0);
        cycle(1, 1, 1, 32'h200, 0, 0);
        cycle(1, 1, 0, 32'h101, 1, 1);
        cycle(1, 1, 1, 32'h201, 0, 0);
        cycle(1, 1, 0, 32'h102, 0, 0);
        cycle(1, 1, 1, 32'h202, 0, 0);
        cycle(1, 1, 0, 32'h103, 0, 0);
        cycle(0, 1, 1, 32'h300, 1, 1);
        cycle(1, 0, 0, 32'h0, 1, 1);
        cycle(1, 0, 1, 32'h0, 1, 1);
        cycle(1, 0, 0, 32'h0, 1, 1);

        for (int i = 0; i < 800; i++) begin
            cycle(($urandom % 64) != 0, ($urandom % 4) != 0, 1'($urandom % 2),
                  $urandom, ($urandom % 3) != 0, 1'($urandom % 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
